reg_read: RTL and testbench
===========================

Name: reg_read

Overview:
- Register-read stage directly downstream of the issue queue and arbiter.
- Takes up to ISSUE_NUM granted instructions per cycle, reads two source operands each from the physical register file, and applies same-cycle writeback bypass.
- Registers the results into a one-deep per-lane pipeline register that feeds the functional units. The FU side uses a valid/ready handshake.
- Owns the physical register file (PRF) storage and its WB_NUM write ports.

Parameters:
- ISSUE_NUM, 4, issue lanes (lane 0/1 ALU, 2 MUL, 3 LOAD)
- WB_NUM, 4, writeback ports into the PRF
- PRF_WIDTH, 6, physical register index width
- PRF_DEPTH, 64, number of physical registers (2**PRF_WIDTH)
- DATA_WIDTH, 64, operand width
- OPCODE, 7, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash pipeline register contents
- iss_valid  in  ISSUE_NUM  lane i carries a granted instruction
- iss_op  in  ISSUE_NUM*OPCODE  opcode per lane
- iss_prs1_v, iss_prs2_v, iss_prd_v  in  ISSUE_NUM each  operand/destination valid flags
- iss_prs1, iss_prs2, iss_prd  in  ISSUE_NUM*PRF_WIDTH each  physical register indices
- iss_ready  out  ISSUE_NUM  lane i can accept this cycle
- wb_valid  in  WB_NUM  writeback valid
- wb_prd  in  WB_NUM*PRF_WIDTH  writeback destination
- wb_data  in  WB_NUM*DATA_WIDTH  writeback data
- fu_valid  out  ISSUE_NUM  FU lane holds an instruction
- fu_ready  in  ISSUE_NUM  FU lane consumes this cycle
- fu_op  out  ISSUE_NUM*OPCODE
- fu_src0, fu_src1  out  ISSUE_NUM*DATA_WIDTH  operands
- fu_prd_v  out  ISSUE_NUM
- fu_prd  out  ISSUE_NUM*PRF_WIDTH

Behaviour:
- Lane i of every flattened vector occupies bits [(i+1)*W-1 : i*W].

PRF storage:
- On rst, all entries are cleared to 0.
- Write: when wb_valid[k] is high, PRF[wb_prd[k]] <= wb_data[k] at the clock edge.
- Writes to p0 are ignored. Reads of p0 always return 0.
- If two wb lanes target the same prd in one cycle, the highest k wins. Issue/rename guarantee this never happens; the bench asserts it.

Operand read (combinational, same cycle as iss_valid):
- If prsN_v = 0, the source is 0.
- Otherwise, if some wb_valid[k] is set with wb_prd[k] == prsN and prsN != 0, the source is wb_data[k] (bypass, highest k wins).
- Otherwise, the source is PRF[prsN].

Handshake:
- iss_ready[i] = ~fu_valid[i] | fu_ready[i]. It is combinational and must not depend on iss_valid.
- Accept on lane i when iss_valid[i] & iss_ready[i]. Next cycle: fu_valid[i] = 1 and all fu_* fields are loaded. Latency is 1 cycle.
- Hold: while fu_valid[i] & ~fu_ready[i], every fu_* output of lane i stays bit-stable. The operands already captured remain correct because a PRF entry is never rewritten while a consumer is in flight.
- Consume without refill: on fu_valid & fu_ready with no accept, fu_valid drops to 0 next cycle. Data fields may hold stale values.
- Back-to-back: consume and accept in the same cycle gives fu_valid = 1 with the new payload.
- Lanes are independent; a stall on one lane never blocks another.

Flush and reset:
- flush (synchronous) clears every fu_valid next cycle and takes priority over an accept in the same cycle.
- flush does not block PRF writes.
- rst clears fu_valid, fu_op, fu_src0/1, fu_prd_v and fu_prd to 0, and clears the PRF.
- rst asserted mid-stall discards held contents; the first accept after reset deassertion is legal on the next cycle.

Optional Feature:
- Macro: REG_READ_BYPASS_EN.
- Defined: same-cycle writeback bypass as specified above.
- Undefined: no bypass mux; operands come from the PRF array only. A value written in cycle T is visible to reads in cycle T+1. The issue wakeup must then delay by one cycle. Write behaviour is unchanged.

Decomposition:
- Shared package: DATA_WIDTH, PRF_WIDTH, OPCODE widths; opcode class constants ALU, MUL, LOAD; per-lane field offset helper functions.
- Sub-module prf_bank holds the storage, write ports, 2*ISSUE_NUM read ports and the bypass mux (under the macro).
- reg_read instantiates one prf_bank and contains the per-lane pipeline registers and handshake.

Test Plan:
- Reset then read: rst 1 cycle. Lane0 issues prs1=5, prs2=0 with both v=1 -> next cycle fu_valid[0]=1, fu_src0=0, fu_src1=0.
- Write then read: wb0 writes p5=0xDEAD in cycle T. Lane1 reads p5 in T+1 -> fu_src0[1]=0xDEAD in T+2.
- Bypass: in the same cycle wb2 writes p9=0x1234 and lane2 reads prs2=p9 -> fu_src1[2]=0x1234 with the macro defined; old value 0 without it. Write to p0 = 0xFF, read p0 -> 0.
- Stall: fu_ready[3]=0 for 3 cycles with fu_valid[3]=1 -> outputs stable and iss_ready[3]=0, while lanes 0-2 keep accepting. Release with a new iss_valid[3] in the same cycle -> new payload next cycle with no bubble.
- Flush: flush is asserted while lanes 0 and 2 are valid and lane1 is accepting -> all fu_valid=0 next cycle. A PRF write in the same cycle is still visible afterwards.
- prs_v=0: lane0 with prs1_v=0, prs1=7 where PRF[7]=0x55 -> fu_src0[0]=0.

Source files
------------

// File: rtl/reg_read_pkg.sv
// ----------------------------------------------------------------------------
// reg_read_pkg: shared widths, lane opcode classes and flattened-field helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package reg_read_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int PRF_WIDTH  = 6;
  localparam int PRF_DEPTH  = 2 ** PRF_WIDTH;
  localparam int OPCODE     = 7;

  // Functional-unit class served by each issue lane (0/1 ALU, 2 MUL, 3 LOAD).
  typedef enum logic [1:0] {
    ALU  = 2'd0,
    MUL  = 2'd1,
    LOAD = 2'd2
  } op_class_e;

  // Lane n of a flattened vector of width-w fields starts at bit n*w.
  function automatic int fld_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_read_if.sv
// ----------------------------------------------------------------------------
// reg_read_if: issue, writeback and functional-unit buses of the read stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface reg_read_if
  import reg_read_pkg::*;
#(
  parameter int ISSUE_NUM = 4,
  parameter int WB_NUM    = 4
) ();

  logic [ISSUE_NUM-1:0]            iss_valid;
  logic [ISSUE_NUM*OPCODE-1:0]     iss_op;
  logic [ISSUE_NUM-1:0]            iss_prs1_v;
  logic [ISSUE_NUM-1:0]            iss_prs2_v;
  logic [ISSUE_NUM-1:0]            iss_prd_v;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]  iss_prs1;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]  iss_prs2;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]  iss_prd;
  logic [ISSUE_NUM-1:0]            iss_ready;

  logic [WB_NUM-1:0]               wb_valid;
  logic [WB_NUM*PRF_WIDTH-1:0]     wb_prd;
  logic [WB_NUM*DATA_WIDTH-1:0]    wb_data;

  logic [ISSUE_NUM-1:0]            fu_valid;
  logic [ISSUE_NUM-1:0]            fu_ready;
  logic [ISSUE_NUM*OPCODE-1:0]     fu_op;
  logic [ISSUE_NUM*DATA_WIDTH-1:0] fu_src0;
  logic [ISSUE_NUM*DATA_WIDTH-1:0] fu_src1;
  logic [ISSUE_NUM-1:0]            fu_prd_v;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]  fu_prd;

  // master: issue/writeback producer and FU consumer; slave: the read stage.
  modport master (
    output iss_valid, iss_op, iss_prs1_v, iss_prs2_v, iss_prd_v,
    output iss_prs1, iss_prs2, iss_prd,
    input  iss_ready,
    output wb_valid, wb_prd, wb_data,
    input  fu_valid, fu_op, fu_src0, fu_src1, fu_prd_v, fu_prd,
    output fu_ready
  );

  modport slave (
    input  iss_valid, iss_op, iss_prs1_v, iss_prs2_v, iss_prd_v,
    input  iss_prs1, iss_prs2, iss_prd,
    output iss_ready,
    input  wb_valid, wb_prd, wb_data,
    output fu_valid, fu_op, fu_src0, fu_src1, fu_prd_v, fu_prd,
    input  fu_ready
  );

endinterface

`default_nettype wire

// File: rtl/reg_read_prf_bank.sv
// ----------------------------------------------------------------------------
// reg_read_prf_bank: physical register file, WB write ports, read ports and
// same-cycle writeback bypass (enabled by REG_READ_BYPASS_EN).   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_read_prf_bank
  import reg_read_pkg::*;
#(
  parameter int RD_NUM = 8,
  parameter int WB_NUM = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic [WB_NUM-1:0]            wb_valid,
  input  wire logic [WB_NUM*PRF_WIDTH-1:0]  wb_prd,
  input  wire logic [WB_NUM*DATA_WIDTH-1:0] wb_data,
  input  wire logic [RD_NUM-1:0]            rd_en,
  input  wire logic [RD_NUM*PRF_WIDTH-1:0]  rd_addr,
  output logic      [RD_NUM*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [PRF_DEPTH];

  // Ascending k means the highest writeback lane wins a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < PRF_DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else begin
      for (int k = 0; k < WB_NUM; k++) begin
        if (wb_valid[k] && (wb_prd[k*PRF_WIDTH +: PRF_WIDTH] != '0)) begin
          r_mem[wb_prd[k*PRF_WIDTH +: PRF_WIDTH]] <= wb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar r = 0; r < RD_NUM; r++) begin : g_rd
    logic [PRF_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_addr = rd_addr[r*PRF_WIDTH +: PRF_WIDTH];

    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REG_READ_BYPASS_EN
      for (int k = 0; k < WB_NUM; k++) begin
        if (wb_valid[k] && (wb_prd[k*PRF_WIDTH +: PRF_WIDTH] == w_addr)) begin
          w_data = wb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`endif
      // Disabled operands and p0 read as zero regardless of storage or bypass.
      if (!rd_en[r] || (w_addr == '0)) begin
        w_data = '0;
      end
    end

    assign rd_data[r*DATA_WIDTH +: DATA_WIDTH] = w_data;
  end

endmodule

`default_nettype wire

// File: rtl/reg_read.sv
// ----------------------------------------------------------------------------
// reg_read: register-read stage with per-lane FU pipeline registers; bypass
// from writeback is selected by REG_READ_BYPASS_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_read
  import reg_read_pkg::*;
#(
  parameter int ISSUE_NUM = 4,
  parameter int WB_NUM    = 4
) (
  input wire logic clk,
  input wire logic rst,
  input wire logic flush,
  reg_read_if.slave bus
);

  localparam int RD_NUM = 2 * ISSUE_NUM;

  logic [RD_NUM-1:0]            w_rd_en;
  logic [RD_NUM*PRF_WIDTH-1:0]  w_rd_addr;
  logic [RD_NUM*DATA_WIDTH-1:0] w_rd_data;

  reg_read_prf_bank #(
    .RD_NUM (RD_NUM),
    .WB_NUM (WB_NUM)
  ) u_prf (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (bus.wb_valid),
    .wb_prd   (bus.wb_prd),
    .wb_data  (bus.wb_data),
    .rd_en    (w_rd_en),
    .rd_addr  (w_rd_addr),
    .rd_data  (w_rd_data)
  );

  for (genvar i = 0; i < ISSUE_NUM; i++) begin : g_lane
    localparam int OL  = fld_lsb(i, OPCODE);
    localparam int PL  = fld_lsb(i, PRF_WIDTH);
    localparam int DL  = fld_lsb(i, DATA_WIDTH);
    localparam int R1A = fld_lsb(2*i, PRF_WIDTH);
    localparam int R2A = fld_lsb(2*i+1, PRF_WIDTH);
    localparam int R1D = fld_lsb(2*i, DATA_WIDTH);
    localparam int R2D = fld_lsb(2*i+1, DATA_WIDTH);

    logic                  r_valid;
    logic [OPCODE-1:0]     r_op;
    logic [DATA_WIDTH-1:0] r_src0;
    logic [DATA_WIDTH-1:0] r_src1;
    logic                  r_prd_v;
    logic [PRF_WIDTH-1:0]  r_prd;
    logic                  w_ready;
    logic                  w_accept;

    // Ready looks only at the lane's own FU side, never at iss_valid.
    assign w_ready  = ~r_valid | bus.fu_ready[i];
    assign w_accept = bus.iss_valid[i] & w_ready;

    assign w_rd_en[2*i]                      = bus.iss_prs1_v[i];
    assign w_rd_en[2*i+1]                    = bus.iss_prs2_v[i];
    assign w_rd_addr[R1A +: PRF_WIDTH]       = bus.iss_prs1[PL +: PRF_WIDTH];
    assign w_rd_addr[R2A +: PRF_WIDTH]       = bus.iss_prs2[PL +: PRF_WIDTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_op    <= '0;
        r_src0  <= '0;
        r_src1  <= '0;
        r_prd_v <= 1'b0;
        r_prd   <= '0;
      end else begin
        if (flush) begin
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_valid <= 1'b1;
        end else if (bus.fu_ready[i]) begin
          r_valid <= 1'b0;
        end
        if (w_accept && !flush) begin
          r_op    <= bus.iss_op[OL +: OPCODE];
          r_src0  <= w_rd_data[R1D +: DATA_WIDTH];
          r_src1  <= w_rd_data[R2D +: DATA_WIDTH];
          r_prd_v <= bus.iss_prd_v[i];
          r_prd   <= bus.iss_prd[PL +: PRF_WIDTH];
        end
      end
    end

    assign bus.iss_ready[i]                 = w_ready;
    assign bus.fu_valid[i]                  = r_valid;
    assign bus.fu_op[OL +: OPCODE]          = r_op;
    assign bus.fu_src0[DL +: DATA_WIDTH]    = r_src0;
    assign bus.fu_src1[DL +: DATA_WIDTH]    = r_src1;
    assign bus.fu_prd_v[i]                  = r_prd_v;
    assign bus.fu_prd[PL +: PRF_WIDTH]      = r_prd;
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_read.sv
// ----------------------------------------------------------------------------
// tb_reg_read: directed scenarios plus randomized traffic against a
// transaction-level model of the register-read stage.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reg_read;
  import reg_read_pkg::*;

  localparam int NI = 4;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  reg_read_if #(.ISSUE_NUM(NI), .WB_NUM(NW)) bus ();

  reg_read #(.ISSUE_NUM(NI), .WB_NUM(NW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus the instruction held per FU lane.
  logic [DATA_WIDTH-1:0] m_prf  [PRF_DEPTH];
  logic                  m_valid[NI];
  logic [OPCODE-1:0]     m_op   [NI];
  logic [DATA_WIDTH-1:0] m_src0 [NI];
  logic [DATA_WIDTH-1:0] m_src1 [NI];
  logic                  m_prdv [NI];
  logic [PRF_WIDTH-1:0]  m_prd  [NI];

  function automatic logic [DATA_WIDTH-1:0] o_src0(input int i);
    return bus.fu_src0[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] o_src1(input int i);
    return bus.fu_src1[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction
  function automatic logic [OPCODE-1:0] o_op(input int i);
    return bus.fu_op[i*OPCODE +: OPCODE];
  endfunction
  function automatic logic [PRF_WIDTH-1:0] o_prd(input int i);
    return bus.fu_prd[i*PRF_WIDTH +: PRF_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ref_read(input logic v, input logic [PRF_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    if (!v || idx == '0) return '0;
    val = m_prf[idx];
`ifdef REG_READ_BYPASS_EN
    for (int k = 0; k < NW; k++)
      if (bus.wb_valid[k] && bus.wb_prd[k*PRF_WIDTH +: PRF_WIDTH] == idx)
        val = bus.wb_data[k*DATA_WIDTH +: DATA_WIDTH];
`endif
    return val;
  endfunction

  // Advance the model with the inputs currently driven, then cross the edge.
  task automatic tick();
    logic [DATA_WIDTH-1:0] s0[NI];
    logic [DATA_WIDTH-1:0] s1[NI];
    logic                  acc[NI];
    for (int i = 0; i < NI; i++) begin
      acc[i] = bus.iss_valid[i] && (!m_valid[i] || bus.fu_ready[i]);
      s0[i]  = ref_read(bus.iss_prs1_v[i], bus.iss_prs1[i*PRF_WIDTH +: PRF_WIDTH]);
      s1[i]  = ref_read(bus.iss_prs2_v[i], bus.iss_prs2[i*PRF_WIDTH +: PRF_WIDTH]);
    end
    if (rst) begin
      for (int e = 0; e < PRF_DEPTH; e++) m_prf[e] = '0;
      for (int i = 0; i < NI; i++) begin
        m_valid[i] = 1'b0; m_op[i] = '0; m_src0[i] = '0;
        m_src1[i] = '0; m_prdv[i] = 1'b0; m_prd[i] = '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (flush) m_valid[i] = 1'b0;
        else if (acc[i]) begin
          m_valid[i] = 1'b1;
          m_op[i]    = bus.iss_op[i*OPCODE +: OPCODE];
          m_src0[i]  = s0[i];
          m_src1[i]  = s1[i];
          m_prdv[i]  = bus.iss_prd_v[i];
          m_prd[i]   = bus.iss_prd[i*PRF_WIDTH +: PRF_WIDTH];
        end else if (bus.fu_ready[i]) m_valid[i] = 1'b0;
      end
      for (int k = 0; k < NW; k++)
        if (bus.wb_valid[k] && bus.wb_prd[k*PRF_WIDTH +: PRF_WIDTH] != '0)
          m_prf[bus.wb_prd[k*PRF_WIDTH +: PRF_WIDTH]] = bus.wb_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid  = '0; bus.iss_op   = '0;
    bus.iss_prs1_v = '0; bus.iss_prs2_v = '0; bus.iss_prd_v = '0;
    bus.iss_prs1   = '0; bus.iss_prs2   = '0; bus.iss_prd   = '0;
    bus.wb_valid   = '0; bus.wb_prd     = '0; bus.wb_data   = '0;
    bus.fu_ready   = '1;
    flush          = 1'b0;
  endtask

  task automatic issue(input int i, input logic [OPCODE-1:0] op,
                       input logic p1v, input logic [PRF_WIDTH-1:0] p1,
                       input logic p2v, input logic [PRF_WIDTH-1:0] p2,
                       input logic pdv, input logic [PRF_WIDTH-1:0] pd);
    bus.iss_valid[i]                      = 1'b1;
    bus.iss_op[i*OPCODE +: OPCODE]        = op;
    bus.iss_prs1_v[i]                     = p1v;
    bus.iss_prs1[i*PRF_WIDTH +: PRF_WIDTH] = p1;
    bus.iss_prs2_v[i]                     = p2v;
    bus.iss_prs2[i*PRF_WIDTH +: PRF_WIDTH] = p2;
    bus.iss_prd_v[i]                      = pdv;
    bus.iss_prd[i*PRF_WIDTH +: PRF_WIDTH]  = pd;
  endtask

  task automatic wb(input int k, input logic [PRF_WIDTH-1:0] prd, input logic [DATA_WIDTH-1:0] data);
    bus.wb_valid[k]                        = 1'b1;
    bus.wb_prd[k*PRF_WIDTH +: PRF_WIDTH]    = prd;
    bus.wb_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (bus.fu_valid !== '0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.fu_valid); end
    total++; if (bus.fu_op !== '0) begin bad++; $display("FAIL rst_op got=%h exp=0", bus.fu_op); end
    total++; if (bus.fu_src0 !== '0 || bus.fu_src1 !== '0) begin bad++; $display("FAIL rst_src got=%h/%h exp=0", bus.fu_src0, bus.fu_src1); end
    total++; if (bus.fu_prd_v !== '0 || bus.fu_prd !== '0) begin bad++; $display("FAIL rst_prd got=%b/%h exp=0", bus.fu_prd_v, bus.fu_prd); end
    total++; if (bus.iss_ready !== 4'b1111) begin bad++; $display("FAIL rst_ready got=%b exp=1111", bus.iss_ready); end
    issue(0, 7'h11, 1'b1, 6'd5, 1'b1, 6'd0, 1'b1, 6'd20); tick(); idle();
    total++; if (bus.fu_valid !== 4'b0001) begin bad++; $display("FAIL first_valid got=%b exp=0001", bus.fu_valid); end
    total++; if (o_src0(0) !== 64'd0 || o_src1(0) !== 64'd0) begin bad++; $display("FAIL first_src got=%h/%h exp=0/0", o_src0(0), o_src1(0)); end
    total++; if (o_op(0) !== 7'h11 || o_prd(0) !== 6'd20 || bus.fu_prd_v[0] !== 1'b1) begin bad++; $display("FAIL first_fields got=%h/%h exp=11/14", o_op(0), o_prd(0)); end
  endtask

  task automatic test_write_read();
    idle(); wb(0, 6'd5, 64'hDEAD); tick();
    idle(); issue(1, 7'h02, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0); tick(); idle();
    total++; if (bus.fu_valid !== 4'b0010) begin bad++; $display("FAIL wr_valid got=%b exp=0010", bus.fu_valid); end
    total++; if (o_src0(1) !== 64'hDEAD) begin bad++; $display("FAIL wr_src0 got=%h exp=dead", o_src0(1)); end
  endtask

  task automatic test_bypass();
    logic [DATA_WIDTH-1:0] exp_byp;
`ifdef REG_READ_BYPASS_EN
    exp_byp = 64'h1234;
`else
    exp_byp = 64'h0;
`endif
    idle(); wb(2, 6'd9, 64'h1234); wb(1, 6'd0, 64'hFF);
    issue(2, 7'h30, 1'b1, 6'd0, 1'b1, 6'd9, 1'b1, 6'd40); tick(); idle();
    total++; if (o_src1(2) !== exp_byp) begin bad++; $display("FAIL bypass_src1 got=%h exp=%h", o_src1(2), exp_byp); end
    total++; if (o_src0(2) !== 64'd0) begin bad++; $display("FAIL p0_bypass got=%h exp=0", o_src0(2)); end
    issue(2, 7'h31, 1'b1, 6'd9, 1'b1, 6'd0, 1'b0, 6'd0); tick(); idle();
    total++; if (o_src0(2) !== 64'h1234 || o_src1(2) !== 64'd0) begin bad++; $display("FAIL after_wb got=%h/%h exp=1234/0", o_src0(2), o_src1(2)); end
  endtask

  task automatic test_prs_v0();
    idle(); wb(3, 6'd7, 64'h55); tick();
    idle(); issue(0, 7'h05, 1'b0, 6'd7, 1'b1, 6'd7, 1'b0, 6'd0); tick(); idle();
    total++; if (o_src0(0) !== 64'd0 || o_src1(0) !== 64'h55) begin bad++; $display("FAIL prs_v0 got=%h/%h exp=0/55", o_src0(0), o_src1(0)); end
  endtask

  task automatic test_stall();
    idle(); bus.fu_ready[3] = 1'b0;
    issue(3, 7'h23, 1'b1, 6'd5, 1'b1, 6'd7, 1'b1, 6'd33); tick();
    total++; if (bus.fu_valid[3] !== 1'b1 || o_src0(3) !== 64'hDEAD || o_src1(3) !== 64'h55) begin bad++; $display("FAIL stall_load got=%b %h/%h exp=1 dead/55", bus.fu_valid[3], o_src0(3), o_src1(3)); end
    for (int c = 0; c < 3; c++) begin
      idle(); bus.fu_ready[3] = 1'b0;
      for (int i = 0; i < 3; i++)
        issue(i, 7'($urandom), 1'b1, (($urandom % 2) != 0) ? 6'd5 : 6'd9, 1'b1, 6'd7, 1'b1, 6'($urandom));
      issue(3, 7'h7F, 1'b1, 6'd9, 1'b1, 6'd9, 1'b0, 6'd1);
      #1;
      total++; if (bus.iss_ready !== 4'b0111) begin bad++; $display("FAIL stall_ready c%0d got=%b exp=0111", c, bus.iss_ready); end
      tick();
      total++; if (bus.fu_valid !== 4'b1111) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=1111", c, bus.fu_valid); end
      total++; if (o_op(3) !== 7'h23 || o_src0(3) !== 64'hDEAD || o_src1(3) !== 64'h55 || o_prd(3) !== 6'd33) begin bad++; $display("FAIL stall_hold c%0d got=%h %h/%h %h", c, o_op(3), o_src0(3), o_src1(3), o_prd(3)); end
      for (int i = 0; i < 3; i++) begin
        total++; if (o_src0(i) !== m_src0[i] || o_op(i) !== m_op[i]) begin bad++; $display("FAIL stall_other lane%0d got=%h exp=%h", i, o_src0(i), m_src0[i]); end
      end
    end
    idle(); issue(3, 7'h24, 1'b1, 6'd9, 1'b1, 6'd5, 1'b1, 6'd34); #1;
    total++; if (bus.iss_ready[3] !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", bus.iss_ready[3]); end
    tick(); idle();
    total++; if (bus.fu_valid[3] !== 1'b1 || o_op(3) !== 7'h24 || o_src0(3) !== 64'h1234 || o_src1(3) !== 64'hDEAD) begin bad++; $display("FAIL release_payload got=%b %h %h/%h", bus.fu_valid[3], o_op(3), o_src0(3), o_src1(3)); end
  endtask

  task automatic test_flush();
    idle(); bus.fu_ready[0] = 1'b0; bus.fu_ready[2] = 1'b0;
    issue(0, 7'h01, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
    issue(2, 7'h03, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0); tick();
    total++; if (bus.fu_valid !== 4'b0101) begin bad++; $display("FAIL flush_setup got=%b exp=0101", bus.fu_valid); end
    idle(); bus.fu_ready[0] = 1'b0; bus.fu_ready[2] = 1'b0; flush = 1'b1;
    issue(1, 7'h02, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0, 6'd0); wb(0, 6'd12, 64'hABC); tick();
    total++; if (bus.fu_valid !== 4'b0000) begin bad++; $display("FAIL flush_valid got=%b exp=0000", bus.fu_valid); end
    idle(); issue(1, 7'h02, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0, 6'd0); tick(); idle();
    total++; if (bus.fu_valid !== 4'b0010 || o_src0(1) !== 64'hABC) begin bad++; $display("FAIL flush_wb got=%b %h exp=0010 abc", bus.fu_valid, o_src0(1)); end
  endtask

  task automatic test_reset_stall();
    idle(); bus.fu_ready[0] = 1'b0; issue(0, 7'h44, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0, 6'd0); tick();
    idle(); bus.fu_ready[0] = 1'b0; rst = 1'b1; tick(); rst = 1'b0; idle();
    total++; if (bus.fu_valid !== '0 || o_src0(0) !== 64'd0) begin bad++; $display("FAIL rst_stall got=%b %h exp=0 0", bus.fu_valid, o_src0(0)); end
    issue(0, 7'h45, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0, 6'd0); tick(); idle();
    total++; if (bus.fu_valid !== 4'b0001 || o_op(0) !== 7'h45 || o_src0(0) !== 64'd0) begin bad++; $display("FAIL rst_reissue got=%b %h %h", bus.fu_valid, o_op(0), o_src0(0)); end
  endtask

  task automatic test_random();
    logic used[16];
    logic [PRF_WIDTH-1:0] p;
    for (int c = 0; c < 400; c++) begin
      idle();
      rst   = (($urandom % 97) == 0);
      flush = (($urandom % 16) == 0);
      bus.fu_ready = 4'($urandom);
      for (int e = 0; e < 16; e++) used[e] = 1'b0;
      for (int k = 0; k < NW; k++) begin
        if (($urandom % 2) != 0) begin
          do p = 6'($urandom % 16); while (used[p[3:0]]);
          used[p[3:0]] = 1'b1;
          wb(k, p, {$urandom, $urandom});
        end
      end
      for (int i = 0; i < NI; i++)
        if (($urandom % 4) != 0)
          issue(i, 7'($urandom), 1'($urandom), 6'($urandom % 16), 1'($urandom),
                6'($urandom % 16), 1'($urandom), 6'($urandom));
      #1;
      for (int i = 0; i < NI; i++) begin
        total++; if (bus.iss_ready[i] !== (!m_valid[i] || bus.fu_ready[i])) begin bad++; $display("FAIL rnd_ready c%0d lane%0d got=%b exp=%b", c, i, bus.iss_ready[i], !m_valid[i] || bus.fu_ready[i]); end
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
        total++; if (bus.fu_valid[i] !== m_valid[i]) begin bad++; $display("FAIL rnd_valid c%0d lane%0d got=%b exp=%b", c, i, bus.fu_valid[i], m_valid[i]); end
        if (m_valid[i]) begin
          total++;
          if (o_op(i) !== m_op[i] || o_src0(i) !== m_src0[i] || o_src1(i) !== m_src1[i] ||
              bus.fu_prd_v[i] !== m_prdv[i] || o_prd(i) !== m_prd[i]) begin
            bad++;
            $display("FAIL rnd_payload c%0d lane%0d got=%h %h/%h %b %h exp=%h %h/%h %b %h", c, i,
                     o_op(i), o_src0(i), o_src1(i), bus.fu_prd_v[i], o_prd(i),
                     m_op[i], m_src0[i], m_src1[i], m_prdv[i], m_prd[i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_prs_v0();
    test_stall();
    test_flush();
    test_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
